team_06_sram_arbiter: RTL
=========================

Name: team_06_sram_arbiter

Overview:
Shares the single wishbone_manager user port between two SRAM requesters. Requester 0 is the delay-line readWrite engine, which is real-time. Requester 1 is a bulk record/playback buffer. The block sequences one transaction at a time: it latches the command, pulses WRITE_I/READ_I, tracks BUSY_O and returns read data with a per-requester ack. It sits between the requesters and wishbone_manager in team_06_top and replaces the direct readWrite-to-manager wiring.

Parameters:
STRICT_PRIO0, 1, 1 = requester 0 always wins a contention; 0 = round-robin.
TIMEOUT, 255, max cycles from the ISSUE cycle to transaction end before abort (8-bit counter).

Ports:
clk  in  1  system clock (hwclk)
nRST  in  1  asynchronous active-low reset
req  in  2  per-requester request level; held until ack
req_we  in  2  1 = write, 0 = read
req_adr  in  2x32  byte address
req_wdat  in  2x32  write data
req_sel  in  2x4  byte select
ack  out  2  one-cycle completion pulse
err  out  2  one-cycle pulse coincident with ack on timeout
rdat  out  2x32  read data, valid from the ack cycle until that requester's next ack
mgr_dat_o  out  32  to CPU_DAT_I
mgr_adr  out  32  to ADR_I
mgr_sel  out  4  to SEL_I
mgr_write  out  1  to WRITE_I, single-cycle pulse
mgr_read  out  1  to READ_I, single-cycle pulse
mgr_dat_i  in  32  from CPU_DAT_O
mgr_busy  in  1  from BUSY_O
arb_busy  out  1  high in any state other than IDLE
grant_id  out  1  index of the current/last granted requester

Behaviour:
- Reset (nRST low, async): state IDLE. All outputs 0: ack, err, rdat, mgr_* and arb_busy. grant_id=1, so requester 0 wins the first round-robin contention. Timeout counter cleared.
- Reset mid-transaction: abort immediately. No ack/err issued. Requesters re-issue after reset.
- States:
  - IDLE: if any req bit is set, choose a winner, latch we/adr/wdat/sel into internal registers, set grant_id, go ISSUE.
  - ISSUE: exactly one cycle. mgr_write=latched_we, mgr_read=!latched_we. Clear the counter. Go WAIT_START.
  - WAIT_START: on mgr_busy=1 go WAIT_END.
  - WAIT_END: on mgr_busy=0 go DONE.
  - DONE: ack[grant_id]=1 for one cycle. For a read, capture rdat[grant_id]<=mgr_dat_i on the WAIT_END->DONE edge, so rdat is valid during the ack cycle. Go IDLE.
- Outputs while active: mgr_adr/mgr_sel/mgr_dat_o are driven from the latched registers in ISSUE, WAIT_START and WAIT_END. They are 0 in IDLE and DONE. mgr_write/mgr_read are 0 outside ISSUE.
- Timeout: counter increments in WAIT_START and WAIT_END. When it reaches TIMEOUT, go DONE with ack and err both pulsed; rdat is left unchanged. Counter saturates and never wraps.
- Arbitration (evaluated only in IDLE):
  - Single requester: that requester wins.
  - Both requesting, STRICT_PRIO0=1: requester 0 wins.
  - Both requesting, STRICT_PRIO0=0: the requester != grant_id wins.
- Latency: req rising in cycle 0 gives ISSUE in cycle 1. Minimum total latency to ack is ISSUE + 1 + (manager busy length) + 1.
- Back-to-back: req still high after ack is treated as a new request in the cycle following DONE. A requester must drop or update req in the ack cycle to avoid a duplicate access.
- Requester drops req mid-transaction: the transaction still completes and ack still pulses.
- Field changes after grant are ignored, because the command is latched in IDLE.
- No mgr_busy activity at all is covered by the timeout.

Decomposition:
- Package team_06_sram_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT_START, WAIT_END, DONE}
  - N_REQ=2
  - TIMEOUT_W=8
  - typedef struct for a latched command {we, adr, wdat, sel}
- Sub-module team_06_rr_pick: combinational winner selection from req, grant_id and STRICT_PRIO0, factored out for unit test.

Test Plan:
1. Reset, then req0 read adr 0x3300_0010, manager model returns 0xDEADBEEF with 3 busy cycles -> mgr_read single pulse; ack[0] 1 cycle; rdat[0]=0xDEADBEEF; err=0.
2. req1 write adr 0x3300_0100, wdat 0x0000_00A5, sel 4'hF -> mgr_write one pulse; mgr_adr/mgr_dat_o stable until busy falls; ack[1]; no change on rdat[1].
3. STRICT_PRIO0=0, both req held high for 4 transactions -> grants 0,1,0,1.
4. STRICT_PRIO0=1, same stimulus -> grants 0,0,0,0 while req0 stays high.
5. Manager never asserts busy -> after 255 cycles ack[g] and err[g] pulse together; state IDLE; next request serviced normally.
6. nRST low during WAIT_END -> all outputs 0 asynchronously; no ack; after release, first contention is won by req0.

Source files
------------

// File: rtl/team_06_sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
// Command fields are latched as one struct when a requester is granted.
package team_06_sram_arb_pkg;

    localparam int unsigned N_REQ     = 2;
    localparam int unsigned TIMEOUT_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitEnd,
        StDone
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
    } arb_cmd_t;

endpackage

// File: rtl/team_06_sram_arbiter_if.sv
// Requester-side and wishbone_manager-side signals of the SRAM arbiter.
// slave is the arbiter's view; master is the requesters plus manager.
interface team_06_sram_arbiter_if;
    import team_06_sram_arb_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_we;
    logic [N_REQ-1:0][31:0] req_adr;
    logic [N_REQ-1:0][31:0] req_wdat;
    logic [N_REQ-1:0][3:0]  req_sel;
    logic [N_REQ-1:0]       ack;
    logic [N_REQ-1:0]       err;
    logic [N_REQ-1:0][31:0] rdat;
    logic [31:0]            mgr_dat_o;
    logic [31:0]            mgr_adr;
    logic [3:0]             mgr_sel;
    logic                   mgr_write;
    logic                   mgr_read;
    logic [31:0]            mgr_dat_i;
    logic                   mgr_busy;
    logic                   arb_busy;
    logic                   grant_id;

    modport slave (
        input  req, req_we, req_adr, req_wdat, req_sel, mgr_dat_i, mgr_busy,
        output ack, err, rdat, mgr_dat_o, mgr_adr, mgr_sel, mgr_write, mgr_read,
               arb_busy, grant_id
    );

    modport master (
        output req, req_we, req_adr, req_wdat, req_sel, mgr_dat_i, mgr_busy,
        input  ack, err, rdat, mgr_dat_o, mgr_adr, mgr_sel, mgr_write, mgr_read,
               arb_busy, grant_id
    );

endinterface

// File: rtl/team_06_rr_pick.sv
// Combinational winner selection between the two requesters.
// last_i is the previously granted index; it only matters for round-robin contention.
module team_06_rr_pick #(
    parameter bit STRICT_PRIO0 = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    always_comb begin
        valid_o  = |req_i;
        winner_o = last_i;
        unique case (req_i)
            2'b00: winner_o = last_i;
            2'b01: winner_o = 1'b0;
            2'b10: winner_o = 1'b1;
            2'b11: winner_o = STRICT_PRIO0 ? 1'b0 : ~last_i;
        endcase
    end

endmodule

// File: rtl/team_06_sram_arbiter.sv
// Shares the wishbone_manager user port between two requesters, one transaction at a time:
// latch in idle, pulse write/read, follow the manager busy window, then ack (or err on timeout).
module team_06_sram_arbiter
    import team_06_sram_arb_pkg::*;
#(
    parameter bit          STRICT_PRIO0 = 1'b1,
    parameter int unsigned TIMEOUT      = 255
) (
    input logic                   clk,
    input logic                   nRST,
    team_06_sram_arbiter_if.slave bus
);

    localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(TIMEOUT);

    arb_state_e             state_q, state_d;
    arb_cmd_t               cmd_q, cmd_d;
    logic                   grant_q, grant_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   to_q, to_d;
    logic [N_REQ-1:0][31:0] rdat_q, rdat_d;
    logic                   pick_valid;
    logic                   pick_id;
    logic                   active;

    team_06_rr_pick #(
        .STRICT_PRIO0 (STRICT_PRIO0)
    ) u_pick (
        .req_i    (bus.req),
        .last_i   (grant_q),
        .valid_o  (pick_valid),
        .winner_o (pick_id)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
            cmd_q   <= '0;
            grant_q <= 1'b1;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdat_q  <= rdat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        rdat_d  = rdat_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d    = pick_id;
                    cmd_d.we   = bus.req_we[pick_id];
                    cmd_d.adr  = bus.req_adr[pick_id];
                    cmd_d.wdat = bus.req_wdat[pick_id];
                    cmd_d.sel  = bus.req_sel[pick_id];
                    to_d       = 1'b0;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart, StWaitEnd: begin
                // Counter stops at the limit, so it can never wrap past it.
                if (cnt_q < TimeoutVal) cnt_d = cnt_q + 1'b1;
                if (cnt_q >= TimeoutVal) begin
                    to_d    = 1'b1;
                    state_d = StDone;
                end else if (state_q == StWaitStart && bus.mgr_busy) begin
                    state_d = StWaitEnd;
                end else if (state_q == StWaitEnd && !bus.mgr_busy) begin
                    if (!cmd_q.we) rdat_d[grant_q] = bus.mgr_dat_i;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        active        = (state_q == StIssue) || (state_q == StWaitStart) ||
                        (state_q == StWaitEnd);
        bus.mgr_adr   = active ? cmd_q.adr  : '0;
        bus.mgr_sel   = active ? cmd_q.sel  : '0;
        bus.mgr_dat_o = active ? cmd_q.wdat : '0;
        bus.mgr_write = (state_q == StIssue) && cmd_q.we;
        bus.mgr_read  = (state_q == StIssue) && !cmd_q.we;
        bus.arb_busy  = (state_q != StIdle);
        bus.grant_id  = grant_q;
        bus.rdat      = rdat_q;
        bus.ack       = '0;
        bus.err       = '0;
        if (state_q == StDone) begin
            bus.ack[grant_q] = 1'b1;
            bus.err[grant_q] = to_q;
        end
    end

endmodule
